// File: rtl/counter_pkg.sv
// Shared definitions for the 3-bit counter: default width/reset value, count type, Gray helper.
package counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 3;
  localparam int CNT_RESET_DEFAULT = 0;

  typedef logic [2:0] cnt_t;

  function automatic cnt_t bin2gray(input cnt_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/tff_sync_rst.sv
// Single T flip-flop with synchronous active-high reset (and power-up value) to INIT.
module tff_sync_rst #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q = INIT;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= INIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_3_bit.sv
// Free-running WIDTH-bit up-counter built from synchronous T flip-flops.
// Optional macro CONTER_3_BIT_GRAY_OUT_EN registers a Gray-coded copy onto cont.
module counter_3_bit
  import counter_pkg::*;
#(
  parameter int               WIDTH       = CNT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(CNT_RESET_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cont
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] tgl;

  // Bit i toggles only when every lower bit is 1; this AND chain is the critical path.
  assign tgl[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_en
    assign tgl[i] = tgl[i-1] & cnt_q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    tff_sync_rst #(
      .INIT (RESET_VALUE[i])
    ) u_tff (
      .clk (clk),
      .rst (rst),
      .t   (tgl[i]),
      .q   (cnt_q[i])
    );
  end

`ifdef CONTER_3_BIT_GRAY_OUT_EN
  localparam logic [WIDTH-1:0] GRAY_RESET = RESET_VALUE ^ (RESET_VALUE >> 1);

  logic [WIDTH-1:0] gray_q = GRAY_RESET;
  logic [WIDTH-1:0] gray_d;

  always_comb begin
    gray_d = cnt_q ^ (cnt_q >> 1);
  end

  // Output register keeps cont glitch-free at the cost of one cycle of lag behind cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= GRAY_RESET;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign cont = gray_q;
`else
  assign cont = cnt_q;
`endif

endmodule

// File: tb/tb_counter_3_bit.sv
// Directed self-checking bench for counter_3_bit (binary build, or Gray build when CONTER_3_BIT_GRAY_OUT_EN is set).
module tb_counter_3_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] cont;

  int checks   = 0;
  int failures = 0;

  counter_3_bit #(
    .WIDTH       (3),
    .RESET_VALUE (3'd0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cont (cont)
  );

  always #10 clk = ~clk;

  task automatic test_powerup();
    logic [2:0] exp;
    #5;
    checks++;
    if (cont !== 3'd0) begin
      failures++;
      $display("FAIL powerup_initial got=%b want=000", cont);
    end
    exp = 3'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp = exp + 3'd1;
      checks++;
      if (cont !== exp) begin
        failures++;
        $display("FAIL powerup_seq edge=%0d got=%b want=%b", k + 1, cont, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (cont !== 3'd0) begin
        failures++;
        $display("FAIL reset_hold edge=%0d got=%b want=000", k, cont);
      end
    end
    rst = 1'b0;
    exp = 3'd0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      exp = exp + 3'd1;
      checks++;
      if (cont !== exp) begin
        failures++;
        $display("FAIL reset_run edge=%0d got=%b want=%b", k + 1, cont, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] wrap_seq [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (cont !== wrap_seq[k]) begin
        failures++;
        $display("FAIL wrap edge=%0d got=%b want=%b", k + 1, cont, wrap_seq[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] exp;
    exp = 3'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp = exp + 3'd1;
      checks++;
      if (cont !== exp) begin
        failures++;
        $display("FAIL mid_reset_approach got=%b want=%b", cont, exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cont !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset_load got=%b want=000", cont);
    end
    @(negedge clk);
    checks++;
    if (cont !== 3'd1) begin
      failures++;
      $display("FAIL mid_reset_release got=%b want=001", cont);
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp;
    exp = 3'd1;
    for (int k = 0; k < 8; k++) begin
      #3 rst = 1'b1;
      #3 rst = 1'b0;
      @(negedge clk);
      exp = exp + 3'd1;
      checks++;
      if (cont !== exp) begin
        failures++;
        $display("FAIL glitch edge=%0d got=%b want=%b", k + 1, cont, exp);
      end
    end
  endtask

  task automatic test_held_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (cont !== 3'd0) begin
        failures++;
        $display("FAIL held_reset edge=%0d got=%b want=000", k, cont);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cont !== 3'd1) begin
      failures++;
      $display("FAIL held_release got=%b want=001", cont);
    end
  endtask

  task automatic test_gray();
    logic [2:0] gray_seq [9] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
    logic [2:0] prev;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cont !== 3'd0) begin
      failures++;
      $display("FAIL gray_reset got=%b want=000", cont);
    end
    rst = 1'b0;
    prev = cont;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (cont !== gray_seq[k]) begin
        failures++;
        $display("FAIL gray_seq edge=%0d got=%b want=%b", k + 1, cont, gray_seq[k]);
      end
      if (k > 0) begin
        checks++;
        if ($countones(cont ^ prev) != 1) begin
          failures++;
          $display("FAIL gray_adjacent edge=%0d got=%b prev=%b want=one_bit_change", k + 1, cont, prev);
        end
      end
      prev = cont;
    end
  endtask

  initial begin
`ifdef CONTER_3_BIT_GRAY_OUT_EN
    test_gray();
`else
    test_powerup();
    test_reset();
    test_wrap();
    test_mid_reset();
    test_glitch();
    test_held_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
